// File: rtl/rangefinder_capture_pkg.sv
// Shared types and constants for the rangefinder sample capture block.
package rangefinder_capture_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPrefill  = 3'd1,
    StWaitTrig = 3'd2,
    StPost     = 3'd3,
    StDone     = 3'd4
  } cap_state_e;

  localparam logic [1:0] RegCtrl    = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegPostLen = 2'd2;
  localparam logic [1:0] RegTrigPtr = 2'd3;

  localparam int unsigned CtrlArm    = 0;
  localparam int unsigned CtrlAbort  = 1;
  localparam int unsigned CtrlIrqClr = 2;
  localparam int unsigned CtrlSwTrig = 3;

  // Post-trigger length is kept within 1..depth.
  function automatic logic [31:0] clamp_len(input logic [31:0] v, input logic [31:0] depth);
    if (v == 32'd0) return 32'd1;
    if (v > depth) return depth;
    return v;
  endfunction

endpackage

// File: rtl/rangefinder_sample_capture_if.sv
// Avalon-MM slave bundle for the rangefinder sample capture block.
interface rangefinder_sample_capture_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W:0] avs_address;
  logic            avs_read;
  logic            avs_write;
  logic [31:0]     avs_writedata;
  logic [31:0]     avs_readdata;
  logic            avs_readdatavalid;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/rangefinder_capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module rangefinder_capture_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/rangefinder_sample_capture.sv
// Circular ADC capture with pre/post-trigger split and rotated Avalon readout.
// Optional software trigger (CTRL bit3) built when RANGEFINDER_CAPTURE_SWTRIG_EN is defined.
module rangefinder_sample_capture
  import rangefinder_capture_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned POST_DEFAULT = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sample_valid,
  input  logic [DATA_W-1:0]            sample_data,
  input  logic                         trigger_in,
  rangefinder_sample_capture_if.slave  avs,
  output logic                         irq
);
  localparam int unsigned Depth    = 2**ADDR_W;
  localparam logic [ADDR_W:0] DepthLen = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LenOne   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] PostRst  = ADDR_W'(POST_DEFAULT) | ((ADDR_W+1)'(POST_DEFAULT));

  cap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d, trig_ptr_q, trig_ptr_d;
  logic [ADDR_W:0]   post_len_q, post_len_d, pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
  logic              irq_q, irq_d, trig_prev_q, trig_prev_d;
  logic              trig_hit;

  logic reg_wr, ctrl_wr, arm, abort, irq_clr, post_len_wr;
  logic [31:0]       len_clamped;
  logic [ADDR_W:0]   pre_len;

  assign reg_wr      = avs.avs_write && !avs.avs_address[ADDR_W];
  assign ctrl_wr     = reg_wr && (avs.avs_address[1:0] == RegCtrl);
  assign arm         = ctrl_wr && avs.avs_writedata[CtrlArm];
  assign abort       = ctrl_wr && avs.avs_writedata[CtrlAbort];
  assign irq_clr     = ctrl_wr && avs.avs_writedata[CtrlIrqClr];
  assign post_len_wr = reg_wr && (avs.avs_address[1:0] == RegPostLen);
  assign len_clamped = clamp_len(avs.avs_writedata, 32'(Depth));
  assign pre_len     = DepthLen - post_len_q;

`ifdef RANGEFINDER_CAPTURE_SWTRIG_EN
  logic sw_pend_q, sw_pend_d;
  assign trig_hit  = (trigger_in && !trig_prev_q) || sw_pend_q;
  // Pending request survives until a valid sample consumes it or WAIT_TRIG is left.
  assign sw_pend_d = (state_d == StWaitTrig) &&
                     (sw_pend_q || (ctrl_wr && avs.avs_writedata[CtrlSwTrig] &&
                                    state_q == StWaitTrig));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sw_pend_q <= 1'b0;
    else          sw_pend_q <= sw_pend_d;
  end
`else
  assign trig_hit = trigger_in && !trig_prev_q;
`endif

  logic ram_we;
  assign ram_we = sample_valid &&
                  (state_q == StPrefill || state_q == StWaitTrig || state_q == StPost);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    trig_ptr_d  = trig_ptr_q;
    post_len_d  = post_len_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    irq_d       = irq_q;
    trig_prev_d = sample_valid ? trigger_in : trig_prev_q;

    if (ram_we) wr_ptr_d = wr_ptr_q + 1'b1;
    if (irq_clr) irq_d = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (post_len_wr) post_len_d = len_clamped[ADDR_W:0];
        if (arm) begin
          pre_cnt_d  = '0;
          post_cnt_d = '0;
          irq_d      = 1'b0;
          state_d    = (post_len_q == DepthLen) ? StWaitTrig : StPrefill;
        end
      end
      StPrefill: begin
        if (sample_valid) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (pre_cnt_q + 1'b1 == pre_len) state_d = StWaitTrig;
        end
      end
      StWaitTrig: begin
        if (sample_valid && trig_hit) begin
          trig_ptr_d = wr_ptr_q;
          post_cnt_d = LenOne;
          if (post_len_q == LenOne) begin
            state_d     = StDone;
            irq_d       = 1'b1;
            start_ptr_d = wr_ptr_q + 1'b1;
          end else begin
            state_d = StPost;
          end
        end
      end
      StPost: begin
        if (sample_valid) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_q + 1'b1 == post_len_q) begin
            state_d     = StDone;
            irq_d       = 1'b1;
            start_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      irq_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      trig_ptr_q  <= '0;
      post_len_q  <= PostRst;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      irq_q       <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      trig_ptr_q  <= trig_ptr_d;
      post_len_q  <= post_len_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      irq_q       <= irq_d;
      trig_prev_q <= trig_prev_d;
    end
  end

  assign irq = irq_q;

  // Read path: window reads rotate by start_ptr so word 0 is the oldest sample.
  logic              ram_re;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [31:0]       reg_rdata_c, reg_rdata_q;
  logic              rdv_q, win_sel_q, win_ok_q;

  assign ram_re  = avs.avs_read && avs.avs_address[ADDR_W];
  assign rd_addr = start_ptr_q + avs.avs_address[ADDR_W-1:0];

  rangefinder_capture_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr_q),
    .wdata(sample_data),
    .re   (ram_re),
    .raddr(rd_addr),
    .rdata(ram_rdata)
  );

  always_comb begin
    reg_rdata_c = '0;
    case (avs.avs_address[1:0])
      RegStatus:  reg_rdata_c = 32'({irq_q, state_q == StDone, state_q});
      RegPostLen: reg_rdata_c = 32'(post_len_q);
      RegTrigPtr: reg_rdata_c = 32'(trig_ptr_q);
      default:    reg_rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdv_q       <= 1'b0;
      win_sel_q   <= 1'b0;
      win_ok_q    <= 1'b0;
      reg_rdata_q <= '0;
    end else begin
      rdv_q <= avs.avs_read;
      if (avs.avs_read) begin
        win_sel_q   <= avs.avs_address[ADDR_W];
        win_ok_q    <= (state_q == StDone);
        reg_rdata_q <= reg_rdata_c;
      end
    end
  end

  assign avs.avs_readdatavalid = rdv_q;
  assign avs.avs_readdata      = win_sel_q ? (win_ok_q ? 32'(ram_rdata) : 32'd0) : reg_rdata_q;
endmodule

// File: tb/tb_rangefinder_sample_capture.sv
// Directed self-checking bench for rangefinder_sample_capture (DEPTH=16, 8-bit samples).
module tb_rangefinder_sample_capture;
  localparam int unsigned DataW = 8;
  localparam int unsigned AddrW = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             sample_valid = 1'b0;
  logic [DataW-1:0] sample_data = '0;
  logic             trigger_in = 1'b0;
  logic             irq;
  int               n_chk = 0;
  int               n_fail = 0;

  rangefinder_sample_capture_if #(.ADDR_W(AddrW)) avs_bus ();

  rangefinder_sample_capture #(
    .DATA_W      (DataW),
    .ADDR_W      (AddrW),
    .POST_DEFAULT(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .trigger_in  (trigger_in),
    .avs         (avs_bus),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    avs_bus.avs_address   = addr;
    avs_bus.avs_writedata = data;
    avs_bus.avs_write     = 1'b1;
    tick();
    avs_bus.avs_write     = 1'b0;
  endtask

  // Checks one-cycle latency, strobe width and that readdata holds after the response.
  task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] got;
    avs_bus.avs_address = addr;
    avs_bus.avs_read    = 1'b1;
    tick();
    avs_bus.avs_read    = 1'b0;
    chk({tag, "_rdv"}, 32'(avs_bus.avs_readdatavalid), 32'd1);
    got = avs_bus.avs_readdata;
    chk(tag, got, exp);
    tick();
    chk({tag, "_rdv_low"}, 32'(avs_bus.avs_readdatavalid), 32'd0);
    chk({tag, "_hold"}, avs_bus.avs_readdata, exp);
  endtask

  // Sample v carries trigger level high when v in [t1a,t1b) or v >= t2a.
  task automatic feed(input int first, input int last, input int t1a, input int t1b,
                      input int t2a, input bit gap);
    for (int v = first; v <= last; v++) begin
      if (gap) begin
        sample_valid = 1'b0;
        trigger_in   = (v >= t1a && v < t1b) || (v >= t2a);
        tick();
      end
      sample_valid = 1'b1;
      sample_data  = DataW'(v);
      trigger_in   = (v >= t1a && v < t1b) || (v >= t2a);
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    trigger_in   = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    avs_bus.avs_address   = '0;
    avs_bus.avs_read      = 1'b0;
    avs_bus.avs_write     = 1'b0;
    avs_bus.avs_writedata = '0;

    // Reset values
    do_reset();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdv", 32'(avs_bus.avs_readdatavalid), 32'd0);
    chk("rst_rdata", avs_bus.avs_readdata, 32'd0);
    rd_chk("rst_status", 5'd1, 32'd0);
    rd_chk("rst_postlen", 5'd2, 32'd4);
    rd_chk("rst_trigptr", 5'd3, 32'd0);

    // 1: basic capture, trigger at sample 20
    wr(5'd2, 32'd4);
    wr(5'd0, 32'h1);
    rd_chk("t1_prefill", 5'd1, 32'd1);
    feed(0, 23, 0, 0, 20, 1'b0);
    chk("t1_irq", 32'(irq), 32'd1);
    rd_chk("t1_status", 5'd1, 32'h1C);
    rd_chk("t1_trigptr", 5'd3, 32'd4);
    for (int k = 0; k < 16; k++) rd_chk("t1_win", 5'(16 + k), 32'(8 + k));
    wr(5'd0, 32'h4);
    chk("t1_irqclr", 32'(irq), 32'd0);
    rd_chk("t1_status_clr", 5'd1, 32'h0C);

    // 2: level held across prefill exit does not fire
    do_reset();
    trigger_in = 1'b1;
    wr(5'd0, 32'h1);
    feed(0, 21, 0, 15, 18, 1'b0);
    rd_chk("t2_status", 5'd1, 32'h1C);
    rd_chk("t2_trigptr", 5'd3, 32'd2);
    rd_chk("t2_win0", 5'd16, 32'd6);
    rd_chk("t2_win15", 5'd31, 32'd21);

    // 3: prefill pulse ignored
    do_reset();
    wr(5'd0, 32'h1);
    feed(0, 29, 5, 6, 30, 1'b0);
    rd_chk("t3_waiting", 5'd1, 32'd2);
    rd_chk("t3_win_notdone", 5'd16, 32'd0);
    feed(30, 33, 5, 6, 30, 1'b0);
    rd_chk("t3_trigptr", 5'd3, 32'd14);
    rd_chk("t3_win0", 5'd16, 32'd18);
    rd_chk("t3_win5", 5'd21, 32'd23);
    rd_chk("t3_win15", 5'd31, 32'd33);

    // 4: abort in POST, ABORT beats ARM, then re-arm
    do_reset();
    wr(5'd0, 32'h1);
    feed(0, 21, 0, 0, 20, 1'b0);
    rd_chk("t4_post", 5'd1, 32'd3);
    wr(5'd0, 32'h3);
    chk("t4_irq", 32'(irq), 32'd0);
    rd_chk("t4_status", 5'd1, 32'd0);
    rd_chk("t4_win", 5'd16, 32'd0);
    trigger_in = 1'b0;
    wr(5'd0, 32'h1);
    feed(40, 55, 0, 0, 52, 1'b0);
    chk("t4_rearm_irq", 32'(irq), 32'd1);
    rd_chk("t4_rearm_status", 5'd1, 32'h1C);
    rd_chk("t4_trigptr", 5'd3, 32'd2);
    rd_chk("t4_win0", 5'd16, 32'd40);
    rd_chk("t4_win15", 5'd31, 32'd55);

    // 5: POST_LEN clamping and write protection
    wr(5'd2, 32'd0);
    rd_chk("t5_len0", 5'd2, 32'd1);
    wr(5'd2, 32'd20);
    rd_chk("t5_len20", 5'd2, 32'd16);
    wr(5'd2, 32'd16);
    rd_chk("t5_len16", 5'd2, 32'd16);
    wr(5'd0, 32'h1);
    rd_chk("t5_skip_prefill", 5'd1, 32'd2);
    wr(5'd2, 32'd5);
    rd_chk("t5_len_locked", 5'd2, 32'd16);
    wr(5'd0, 32'h2);
    rd_chk("t5_abort", 5'd1, 32'd0);

    // 6: 50% valid, trigger edge on an invalid cycle
    do_reset();
    wr(5'd2, 32'd4);
    wr(5'd0, 32'h1);
    feed(0, 23, 0, 0, 20, 1'b1);
    rd_chk("t6_status", 5'd1, 32'h1C);
    rd_chk("t6_trigptr", 5'd3, 32'd4);
    rd_chk("t6_win0", 5'd16, 32'd8);
    rd_chk("t6_win7", 5'd23, 32'd15);
    rd_chk("t6_win15", 5'd31, 32'd23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rangefinder_sample_capture.md
Name: rangefinder_sample_capture

Overview:
Parametrised successor to the fixed 256x8 dual-port sample RAM. It captures a continuous ADC sample stream into a circular buffer with programmable pre- and post-trigger split. The captured record is exposed to the Nios host over one Avalon-MM slave, rotated so word 0 is always the oldest sample. Sits between the receiver ADC front end and the SOPC interconnect. Single clock domain.

Parameters:
DATA_W, 8, sample width in bits, 1..32
ADDR_W, 8, buffer depth = 2**ADDR_W samples, 4..12
POST_DEFAULT, 64, reset value of POST_LEN register, 1..2**ADDR_W

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sample_valid  in  1  sample_data valid this cycle
sample_data  in  DATA_W  ADC sample
trigger_in  in  1  hardware trigger level; rising edge qualified by sample_valid
avs_address  in  ADDR_W+1  MSB=1: buffer window; MSB=0: register (low 2 bits)
avs_read  in  1  Avalon read strobe
avs_write  in  1  Avalon write strobe
avs_writedata  in  32  write data
avs_readdata  out  32  read data, zero-extended
avs_readdatavalid  out  1  read response strobe
irq  out  1  capture-done interrupt, level

Behaviour:
- Reset values: avs_readdata=0, avs_readdatavalid=0, irq=0, state=IDLE, wr_ptr=0, POST_LEN=POST_DEFAULT, trig_ptr=0.
- Registers: 0 CTRL (W): bit0 ARM, bit1 ABORT, bit2 IRQ_CLR. 1 STATUS (R): bits[2:0] state code, bit3 done, bit4 irq. 2 POST_LEN (RW, ADDR_W+1 bits). 3 TRIG_PTR (R): physical address of trigger sample.
- Read latency fixed at 1: avs_readdatavalid pulses the cycle after avs_read; avs_readdata is held until the next read.
- States: IDLE(0), PREFILL(1), WAIT_TRIG(2), POST(3), DONE(4).
- IDLE/DONE + ARM -> PREFILL; clears pre_cnt, post_cnt and irq.
- PREFILL: each valid sample is written at wr_ptr, then wr_ptr++ mod 2**ADDR_W.
  - After DEPTH-POST_LEN samples -> WAIT_TRIG.
  - Triggers during PREFILL are ignored.
- WAIT_TRIG: continues circular writes. A valid sample with trigger_in=1 while the previous valid sample saw trigger_in=0 -> POST.
  - The edge detector updates only on valid samples.
  - A level held high across PREFILL exit does not fire.
  - The trigger sample is post sample 0; its address is latched into TRIG_PTR.
- POST: after POST_LEN valid samples (including the trigger sample) -> DONE. Set irq; freeze start_ptr = wr_ptr (oldest sample).
- Buffer window: read of word k in DONE returns mem[(start_ptr+k) mod DEPTH]. In any other state it returns 0. Writes to the window are ignored.
- POST_LEN write accepted only in IDLE/DONE; ignored otherwise.
  - 0 is stored as 1; values >DEPTH are stored as DEPTH.
  - POST_LEN=DEPTH means PREFILL is skipped (zero length) and the FSM enters WAIT_TRIG directly.
- ABORT in any state -> IDLE, irq=0. ABORT and ARM in the same write: ABORT wins.
- ARM while in PREFILL/WAIT_TRIG/POST is ignored.
- IRQ_CLR clears irq only; state stays DONE.
- Buffer read and sample write on the same cycle have no conflict: separate RAM ports. Writes never occur in DONE.
- reset_n low mid-capture: immediate return to reset values. Buffer contents are undefined.

Optional Feature:
RANGEFINDER_CAPTURE_SWTRIG_EN
- Defined: CTRL bit3 SW_TRIG in WAIT_TRIG forces the trigger on the next valid sample, same as a hardware edge. It is ignored in other states.
- Undefined: bit3 is ignored and no extra logic is built.

Decomposition:
- Package rangefinder_capture_pkg holds:
  - state enum, including codes
  - register offsets
  - CTRL bit indices
- Sub-module rangefinder_capture_ram: simple dual-port RAM, DATA_W x 2**ADDR_W, one write port, one registered read port, inferred (no vendor primitive).

Test Plan:
Use ADDR_W=4 (DEPTH=16) and DATA_W=8 throughout.
1. POST_LEN=4, ARM, samples 0,1,2,... every cycle, trigger rises at sample 20 -> DONE after sample 23, irq=1, TRIG_PTR=4, window words 0..15 read 8..23.
2. trigger_in held high from before ARM through PREFILL, drops at sample 15, rises at 18 -> trigger sample is 18, not 12.
3. Trigger pulse at sample 5 (during PREFILL), real edge at 30 -> pulse ignored; capture around 30.
4. ABORT in POST -> STATUS state=0, irq=0, window reads 0. Re-ARM works and completes normally.
5. POST_LEN writes of 0, 20 and 16 -> read back 1, 16 and 16. A POST_LEN write during WAIT_TRIG leaves the value unchanged.
6. Sample_valid toggling 50% with trigger edge on an invalid cycle held to the next valid cycle -> trigger on that valid sample. Readdatavalid exactly 1 cycle after each read.
